// File: rtl/block_serializer.sv
// Block-to-element serializer: buffers up to DEPTH blocks of LANES elements
// and emits one element per consumer request, with last flag and flush.
module block_serializer #(
    parameter int LANES     = 16,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [LANES-1:0][WIDTH-1:0] block_in,
    input  logic                        block_valid_in,
    output logic                        block_ready_out,
    input  logic                        request_in,
    input  logic                        flush_in,
    output logic [WIDTH-1:0]            result_out,
    output logic                        valid_out,
    output logic                        last_out,
    output logic                        busy_out
);

    localparam int IW = $clog2(LANES);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [LANES-1:0][WIDTH-1:0] block_t;
    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state_q, state_d;
    block_t           mem_q [DEPTH];
    block_t           mem_d [DEPTH];
    logic [HW-1:0]    head_q, head_d, tail;
    logic [CW-1:0]    count_q, count_d;
    logic [IW-1:0]    idx_q, idx_d, lane;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             accept, service, wrap;

    // Ready depends only on registered occupancy, never on request_in.
    assign block_ready_out = rst_in && (count_q < CW'(DEPTH)) && !flush_in;
    assign accept  = block_valid_in && block_ready_out;
    assign service = (state_q == STREAM) && request_in && !flush_in;
    assign wrap    = (idx_q == IW'(LANES - 1));
    assign lane    = MSB_FIRST ? (IW'(LANES - 1) - idx_q) : idx_q;
    assign tail    = HW'((int'(head_q) + int'(count_q)) % DEPTH);

    always_comb begin
        mem_d    = mem_q;
        head_d   = head_q;
        count_d  = count_q;
        idx_d    = idx_q;
        result_d = result_q;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        if (flush_in) begin
            head_d   = '0;
            count_d  = '0;
            idx_d    = '0;
            result_d = '0;
        end else begin
            if (accept) begin
                mem_d[tail] = block_in;
                count_d     = count_d + CW'(1);
            end
            if (service) begin
                valid_d  = 1'b1;
                last_d   = wrap;
                result_d = mem_q[head_q][lane];
                if (wrap) begin
                    idx_d   = '0;
                    count_d = count_d - CW'(1);
                    head_d  = (head_q == HW'(DEPTH - 1)) ? '0
                                                         : head_q + HW'(1);
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
        end
        state_d = (count_d != '0) ? STREAM : IDLE;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            state_q  <= IDLE;
            head_q   <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            state_q  <= state_d;
            head_q   <= head_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    assign result_out = result_q;
    assign valid_out  = valid_q;
    assign last_out   = last_q;
    assign busy_out   = (state_q == STREAM);

endmodule

// File: doc/block_serializer.md
# block_serializer

Parametrised block-to-element serializer, the successor to the fixed 16-byte block streamer. It accepts whole blocks of `LANES` elements over a valid/ready handshake and buffers up to `DEPTH` of them. It emits one element per consumer request, in configurable order, with a last-element flag and a flush. It sits between the block-producing cipher/packet stages and any byte-wide consumer, such as the UART/transmit path.

## Interface
Parameters:
- `LANES`, 16, elements per block (>= 2)
- `WIDTH`, 8, bits per element
- `DEPTH`, 2, blocks of storage (1 or 2)
- `MSB_FIRST`, 1, 1 = emit lane `LANES-1` first, 0 = emit lane 0 first

Ports:
- `clk_in`  in  1  single clock, all logic on rising edge
- `rst_in`  in  1  synchronous, active-low reset
- `block_in`  in  `LANES*WIDTH`  packed `[LANES-1:0][WIDTH-1:0]` block
- `block_valid_in`  in  1  producer offers `block_in`
- `block_ready_out`  out  1  a slot is free; a transfer occurs when valid and ready are both high
- `request_in`  in  1  consumer asks for the next element
- `flush_in`  in  1  discard all stored blocks
- `result_out`  out  `WIDTH`  element data
- `valid_out`  out  1  `result_out` is valid this cycle (one-cycle pulse per serviced request)
- `last_out`  out  1  high with `valid_out` on the final element of a block
- `busy_out`  out  1  state is STREAM

## Operation
- Storage is a block FIFO of `DEPTH` slots, holding a head slot and a count.
- Lane index `idx` runs from 0 to `LANES-1`. The emitted lane is `LANES-1-idx` if `MSB_FIRST`, else `idx`.
- States:
  - IDLE: count == 0. Requests are ignored.
  - STREAM: count > 0.
- IDLE -> STREAM on the cycle after a block is accepted.
- In STREAM, `request_in` high services one element:
  - Next cycle: `valid_out`=1, `result_out`=element, `last_out`=(idx==`LANES-1`).
  - `idx` increments.
- On servicing idx==`LANES-1`:
  - `idx` returns to 0 and the head slot is freed (count decrements).
  - If count stays > 0, remain in STREAM; the next request serves the next block with no bubble.
  - Otherwise go to IDLE.
- `block_ready_out` = (count < `DEPTH`) and not `flush_in`. It is derived from registered count only, so there is no combinational path from `request_in`.
- A full FIFO freeing its head and seeing a valid block in the same cycle does not accept the block. Ready rises the following cycle.
- Acceptance and service in the same cycle are allowed when count > 0. Both update count (net unchanged).
- `flush_in` has priority over request and acceptance. On the next cycle:
  - count=0, idx=0, state IDLE
  - `valid_out`=0, `last_out`=0, `result_out`=0
- Between pulses, `result_out` holds its last value. `last_out` is 0 whenever `valid_out` is 0.
- Element width is `WIDTH`. Index and count widths are `$clog2(LANES)` and `$clog2(DEPTH+1)`. No wrap beyond `LANES-1`.

## Timing
- Reset (`rst_in` low at an edge):
  - Outputs: `result_out`=0, `valid_out`=0, `last_out`=0, `busy_out`=0.
  - Internal: count=0, idx=0, IDLE.
  - `block_ready_out`=0 while `rst_in` is low, and 1 the first cycle after release.
- Reset mid-stream discards everything. It overrides flush and requests.
- Block accepted at cycle T: `busy_out`=1 at T+1. A request at T is ignored if count was 0. The earliest request is at T+1, with `valid_out` at T+2.
- Request-to-`valid_out` latency is 1 cycle. Throughput is 1 element/cycle with `request_in` held high.
- With `DEPTH`=2 and the producer refilling promptly: back-to-back blocks produce `2*LANES` consecutive `valid_out` cycles.
- `busy_out` falls the cycle after the final element of the final stored block is serviced.

## Test plan
- Defaults; one block with lane i = i (0x00..0x0F); `request_in` held high from T+1 -> 16 consecutive `valid_out`, data 0x0F..0x00, `last_out` only on 0x00, `busy_out`=0 after.
- `MSB_FIRST`=0, same stimulus -> data 0x00..0x0F, `last_out` on 0x0F.
- `DEPTH`=2; blocks A (0x00..0x0F) and B (0x10..0x1F) back-to-back, third block C offered -> 32 consecutive `valid_out` with no gaps, `last_out` at elements 16 and 32, C held off (ready=0) until A's final element is serviced plus one cycle.
- `request_in` pulsed every 3rd cycle -> each `valid_out` exactly 1 cycle after its request, order intact, `result_out` stable between pulses; requests in IDLE produce no `valid_out`.
- `flush_in` after 5 elements of A with B queued -> next cycle `valid_out`=0, `busy_out`=0, ready=1, `result_out`=0; a new block D streams from D lane 15.
- `rst_in` low mid-stream with `request_in` high -> all outputs 0, ready 0 during reset, ready 1 after release, no residual elements.
